router_pkt_fifo: RTL and testbench

//  Parametrised packet-aware FIFO for the router output channels; next generation of the per-port FIFO.

---
 rtl/router_pkt_fifo.sv | 110 +++++++++++
 tb/tb_router_pkt_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - packet-aware output-channel FIFO with level, watermarks and sticky error flags
module router_pkt_fifo #(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 16,
    parameter  int AF_THRESH = 14,
    parameter  int AE_THRESH = 2,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_reset,
    input  logic              wr_en,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_hdr,
    output logic              dout_last,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int LVL_W = ADDR_W + 1;
    localparam int CNT_W = DATA_W - 1;

    localparam logic [LVL_W-1:0] PTR_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] AF_LVL  = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] AE_LVL  = LVL_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Each entry carries the header flag above the data word.
    logic [DATA_W:0]    mem [DEPTH];
    logic [LVL_W-1:0]   wr_ptr;
    logic [LVL_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   pkt_cnt;
    logic [DATA_W:0]    rd_word;
    logic [CNT_W-1:0]   hdr_cnt;
    logic               do_wr;
    logic               do_rd;
    logic               rd_is_hdr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign level = wr_ptr - rd_ptr;

    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    // A full FIFO refuses the write and an empty one refuses the read, which
    // gives the simultaneous read/write priority without extra logic.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_word   = mem[rd_ptr[ADDR_W-1:0]];
    assign rd_is_hdr = rd_word[DATA_W];
    // Header length counts payload only; one more for the trailing parity word.
    assign hdr_cnt   = {1'b0, rd_word[DATA_W-1:2]} + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst && !soft_reset && do_wr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, din};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_hdr   <= 1'b0;
            dout_last  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end

            dout_valid <= do_rd;
            if (do_rd) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                dout      <= rd_word[DATA_W-1:0];
                dout_hdr  <= rd_is_hdr;
                dout_last <= !rd_is_hdr && (pkt_cnt == CNT_ONE);
                // A header always reloads, even if the previous packet was cut short.
                if (rd_is_hdr) begin
                    pkt_cnt <= hdr_cnt;
                end else if (pkt_cnt != '0) begin
                    pkt_cnt <= pkt_cnt - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - randomized self-checking bench for router_pkt_fifo against a queue model
module tb_router_pkt_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       soft_reset = 1'b0;
    logic       wr_en = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, dout_hdr, dout_last;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] level;
    logic       overflow, underflow;

    int checks = 0;
    int failures = 0;

    logic [8:0] mq [$];
    int         m_rem;
    bit         m_ovf, m_unf;
    bit         exp_valid, exp_hdr, exp_last;
    logic [7:0] exp_dout;

    router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
        .clk(clk), .rst(rst), .soft_reset(soft_reset),
        .wr_en(wr_en), .lfd_state(lfd_state), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .dout_hdr(dout_hdr), .dout_last(dout_last),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_rem = 0;
        m_ovf = 0;
        m_unf = 0;
        exp_valid = 0;
        exp_hdr = 0;
        exp_last = 0;
        exp_dout = 8'h00;
    endtask

    // Drives one cycle and advances the model from the pre-edge occupancy.
    task automatic step(input bit wr, input bit lfd, input logic [7:0] d, input bit rd);
        bit f, e;
        logic [8:0] w;
        wr_en = wr;
        lfd_state = lfd;
        din = d;
        rd_en = rd;
        f = (mq.size() == 16);
        e = (mq.size() == 0);
        if (wr && f) m_ovf = 1;
        if (rd && e) m_unf = 1;
        exp_valid = rd && !e;
        if (rd && !e) begin
            w = mq.pop_front();
            exp_dout = w[7:0];
            exp_hdr = w[8];
            if (w[8]) begin
                exp_last = 0;
                m_rem = int'(w[7:2]) + 1;
            end else begin
                exp_last = (m_rem == 1);
                if (m_rem > 0) m_rem--;
            end
        end
        if (wr && !f) mq.push_back({lfd, d});
        @(posedge clk);
        #1;
        wr_en = 0;
        rd_en = 0;
        lfd_state = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        @(posedge clk);
        #1;
        rst = 1;
        model_clear();
        checks++;
        if ({empty, full, level, dout, dout_valid, overflow, underflow, almost_empty} !==
            {1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got e=%b f=%b lvl=%0d dout=%h v=%b ovf=%b unf=%b ae=%b want e=1 f=0 lvl=0 dout=00 v=0 ovf=0 unf=0 ae=1",
                     empty, full, level, dout, dout_valid, overflow, underflow, almost_empty);
        end
    endtask

    task automatic test_packet();
        logic [7:0] words [5];
        words[0] = 8'h0C; words[1] = 8'hA1; words[2] = 8'hA2; words[3] = 8'hA3; words[4] = 8'h55;
        for (int i = 0; i < 5; i++) step(1, i == 0, words[i], 0);
        checks++;
        if (level !== 5'd5) begin
            failures++;
            $display("FAIL pkt_level: got %0d want 5", level);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 1);
            checks++;
            if ({dout_valid, dout_hdr, dout_last, dout} !== {1'b1, i == 0, i == 4, words[i]} ||
                {dout_hdr, dout_last, dout} !== {exp_hdr, exp_last, exp_dout}) begin
                failures++;
                $display("FAIL pkt_read%0d: got v=%b h=%b l=%b d=%h want v=1 h=%b l=%b d=%h",
                         i, dout_valid, dout_hdr, dout_last, dout, i == 0, i == 4, words[i]);
            end
        end
        step(0, 0, 8'h00, 0);
        checks++;
        if ({dout_valid, dout, empty} !== {1'b0, 8'h55, 1'b1}) begin
            failures++;
            $display("FAIL pkt_idle_hold: got v=%b d=%h e=%b want v=0 d=55 e=1", dout_valid, dout, empty);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'($urandom), 0);
            checks++;
            if ({level, full, almost_full, almost_empty} !==
                {5'(i + 1), i == 15, (i + 1) >= 14, (i + 1) <= 2}) begin
                failures++;
                $display("FAIL fill%0d: got lvl=%0d f=%b af=%b ae=%b want lvl=%0d f=%b af=%b ae=%b",
                         i, level, full, almost_full, almost_empty, i + 1, i == 15, (i + 1) >= 14, (i + 1) <= 2);
            end
        end
        step(1, 0, 8'hEE, 0);
        checks++;
        if ({overflow, full, level} !== {1'b1, 1'b1, 5'd16}) begin
            failures++;
            $display("FAIL overflow: got ovf=%b f=%b lvl=%0d want ovf=1 f=1 lvl=16", overflow, full, level);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 1);
            checks++;
            if ({dout_valid, dout, level} !== {1'b1, exp_dout, 5'(mq.size())}) begin
                failures++;
                $display("FAIL drain%0d: got v=%b d=%h lvl=%0d want v=1 d=%h lvl=%0d",
                         i, dout_valid, dout, level, exp_dout, mq.size());
            end
        end
        checks++;
        if ({empty, overflow} !== {1'b1, 1'b1}) begin
            failures++;
            $display("FAIL drain_empty: got e=%b ovf=%b want e=1 ovf=1", empty, overflow);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) step(1, 0, 8'($urandom), 0);
        step(1, 0, 8'h77, 1);
        checks++;
        if ({level, dout_valid, dout, full} !== {5'd15, 1'b1, exp_dout, 1'b0}) begin
            failures++;
            $display("FAIL rw_full: got lvl=%0d v=%b d=%h f=%b want lvl=15 v=1 d=%h f=0",
                     level, dout_valid, dout, full, exp_dout);
        end
        while (mq.size() > 0) step(0, 0, 8'h00, 1);
        step(1, 0, 8'h99, 1);
        checks++;
        if ({level, dout_valid, underflow} !== {5'd1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rw_empty: got lvl=%0d v=%b unf=%b want lvl=1 v=0 unf=1", level, dout_valid, underflow);
        end
        step(0, 0, 8'h00, 1);
        checks++;
        if ({dout_valid, dout} !== {1'b1, 8'h99}) begin
            failures++;
            $display("FAIL rw_empty_data: got v=%b d=%h want v=1 d=99", dout_valid, dout);
        end
    endtask

    task automatic test_stream();
        int written = 0;
        int iter = 0;
        bit wr, rd, lfd;
        while (written < 40 && iter < 400) begin
            wr = (mq.size() < 12) && (mq.size() < 5 || $urandom_range(1) == 1);
            rd = (mq.size() > 5) && $urandom_range(1) == 1;
            lfd = ($urandom_range(3) == 0);
            step(wr, lfd, 8'($urandom), rd);
            if (wr) written++;
            iter++;
            checks++;
            if (int'(level) != mq.size() || dout_valid !== exp_valid ||
                (exp_valid && {dout_hdr, dout_last, dout} !== {exp_hdr, exp_last, exp_dout})) begin
                failures++;
                $display("FAIL stream%0d: got lvl=%0d v=%b h=%b l=%b d=%h want lvl=%0d v=%b h=%b l=%b d=%h",
                         iter, level, dout_valid, dout_hdr, dout_last, dout,
                         mq.size(), exp_valid, exp_hdr, exp_last, exp_dout);
            end
        end
        checks++;
        if (written != 40) begin
            failures++;
            $display("FAIL stream_budget: got %0d writes want 40", written);
        end
        while (mq.size() > 0) begin
            step(0, 0, 8'h00, 1);
            checks++;
            if ({dout_hdr, dout_last, dout} !== {exp_hdr, exp_last, exp_dout}) begin
                failures++;
                $display("FAIL stream_drain: got h=%b l=%b d=%h want h=%b l=%b d=%h",
                         dout_hdr, dout_last, dout, exp_hdr, exp_last, exp_dout);
            end
        end
    endtask

    task automatic test_soft_reset();
        // Header length 6 -> 7 non-header words; after hdr + 5 reads the counter is at 2.
        step(1, 1, 8'h18, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1);
        checks++;
        if (level !== 5'd7) begin
            failures++;
            $display("FAIL sr_setup_level: got %0d want 7", level);
        end
        soft_reset = 1;
        wr_en = 1;
        din = 8'h42;
        @(posedge clk);
        #1;
        soft_reset = 0;
        wr_en = 0;
        model_clear();
        checks++;
        if ({empty, level, overflow, underflow, dout_valid, dout} !== {1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL soft_reset: got e=%b lvl=%0d ovf=%b unf=%b v=%b d=%h want e=1 lvl=0 ovf=0 unf=0 v=0 d=00",
                     empty, level, overflow, underflow, dout_valid, dout);
        end
        // Two headerless words: a surviving counter of 2 would mark the second as last.
        step(1, 0, 8'h31, 0);
        step(1, 0, 8'h32, 0);
        step(1, 1, 8'h04, 0);
        step(1, 0, 8'hB1, 0);
        step(1, 0, 8'hB2, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 1);
            checks++;
            if ({dout_valid, dout_hdr, dout_last, dout} !== {1'b1, exp_hdr, exp_last, exp_dout} ||
                dout_last !== (i == 4)) begin
                failures++;
                $display("FAIL sr_pkt%0d: got v=%b h=%b l=%b d=%h want v=1 h=%b l=%b d=%h",
                         i, dout_valid, dout_hdr, dout_last, dout, exp_hdr, i == 4, exp_dout);
            end
        end
        step(0, 0, 8'h00, 1);
        checks++;
        if ({underflow, dout_valid, empty} !== {1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sr_underflow: got unf=%b v=%b e=%b want unf=1 v=0 e=1", underflow, dout_valid, empty);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_packet();
        test_full();
        test_simultaneous();
        test_stream();
        test_soft_reset();
        checks++;
        if ({overflow, underflow} !== {m_ovf, m_unf}) begin
            failures++;
            $display("FAIL sticky_final: got ovf=%b unf=%b want ovf=%b unf=%b", overflow, underflow, m_ovf, m_unf);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
